// File: rtl/display_grid.sv
// display_grid: renders a Game-of-Life style cell grid onto a pixel stream.
//
// Each valid pixel is mapped to a cell. The cell state is read from an
// external RAM, and the pixel is coloured according to the palette mode that
// was latched at frame start. A blinking cursor can be drawn over one cell.
// The pipeline has a fixed latency of three cycles and never stalls.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pix_valid, x, y            pixel coordinate stream
//   hsync_in, vsync_in         timing strobes, delayed to hsync_out/vsync_out
//   mode                       palette: 0 mono, 1 age, 2 age + grid, 3 = mono
//   cursor_en/col/row          cursor cell, sampled with each pixel
//   cell_rd_en/addr/data       cell RAM read port, addr = {row,col}, 1-cycle latency
//   rgb, rgb_valid             4:4:4 pixel colour out
//   hsync_out, vsync_out       delayed timing strobes
module display_grid #(
    parameter int unsigned CELL_LOG2    = 7,
    parameter int unsigned COLS_LOG2    = 2,
    parameter int unsigned ROWS_LOG2    = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_valid,
    input  logic [10:0]                        x,
    input  logic [10:0]                        y,
    input  logic                               hsync_in,
    input  logic                               vsync_in,
    input  logic [1:0]                         mode,
    input  logic                               cursor_en,
    input  logic [COLS_LOG2-1:0]               cursor_col,
    input  logic [ROWS_LOG2-1:0]               cursor_row,
    output logic                               cell_rd_en,
    output logic [COLS_LOG2+ROWS_LOG2-1:0]     cell_rd_addr,
    input  logic [1:0]                         cell_rd_data,
    output logic [11:0]                        rgb,
    output logic                               rgb_valid,
    output logic                               hsync_out,
    output logic                               vsync_out
);

    localparam int unsigned AW    = COLS_LOG2 + ROWS_LOG2;
    localparam int unsigned FCW   = $clog2(BLINK_FRAMES) + 1;
    localparam int unsigned XSPAN = CELL_LOG2 + COLS_LOG2;
    localparam int unsigned YSPAN = CELL_LOG2 + ROWS_LOG2;

    localparam logic [FCW-1:0] FC_LAST   = FCW'(BLINK_FRAMES - 1);
    localparam logic [10:0]    CELL_MASK = 11'((32'd1 << CELL_LOG2) - 32'd1);

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_WHITE  = 12'hFFF;
    localparam logic [11:0] RGB_RED    = 12'hF00;
    localparam logic [11:0] RGB_YELLOW = 12'hFF0;
    localparam logic [11:0] RGB_GREEN  = 12'h0F0;
    localparam logic [11:0] RGB_GRID   = 12'h444;
    localparam logic [11:0] RGB_CURSOR = 12'h00F;

    // Frame-level state
    logic [1:0]     mode_q, mode_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           blink_q, blink_d;
    // Blink phase that applies to the frame currently being drawn
    logic           frame_blink_q, frame_blink_d;

    // Stage 1 (read issue)
    logic          cell_rd_en_q, cell_rd_en_d;
    logic [AW-1:0] cell_rd_addr_q, cell_rd_addr_d;
    logic s1_valid_q, s1_valid_d, s1_inr_q, s1_inr_d, s1_age_q, s1_age_d;
    logic s1_grid_q, s1_grid_d, s1_cur_q, s1_cur_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;

    // Stage 2 (RAM data arrives)
    logic s2_valid_q, s2_inr_q, s2_age_q, s2_grid_q, s2_cur_q, s2_hs_q, s2_vs_q;

    // Stage 3 (registered outputs)
    logic [11:0] rgb_q, rgb_d;
    logic        rgb_valid_q, rgb_valid_d;
    logic        hsync_q, vsync_q;

    // Stage 0 decode
    logic [COLS_LOG2-1:0] col;
    logic [ROWS_LOG2-1:0] row;
    logic                 in_range, frame_start, blink_eff, on_grid_line;
    logic [1:0]           mode_eff;

    always_comb begin
        col          = x[CELL_LOG2 +: COLS_LOG2];
        row          = y[CELL_LOG2 +: ROWS_LOG2];
        in_range     = ((32'(x) >> XSPAN) == 32'd0) && ((32'(y) >> YSPAN) == 32'd0);
        frame_start  = pix_valid && (x == 11'd0) && (y == 11'd0);
        // The frame-start pixel already belongs to the new frame's mode.
        mode_eff     = frame_start ? mode : mode_q;
        // Counter updates at frame start take effect from the following frame.
        blink_eff    = frame_start ? blink_q : frame_blink_q;
        on_grid_line = ((x & CELL_MASK) == 11'd0) || ((y & CELL_MASK) == 11'd0);

        mode_d        = mode_q;
        fc_d          = fc_q;
        blink_d       = blink_q;
        frame_blink_d = frame_blink_q;
        if (frame_start) begin
            mode_d        = mode;
            frame_blink_d = blink_q;
            if (fc_q == FC_LAST) begin
                fc_d    = '0;
                blink_d = ~blink_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end

        cell_rd_en_d   = pix_valid && in_range;
        cell_rd_addr_d = cell_rd_en_d ? {row, col} : cell_rd_addr_q;
        s1_valid_d     = pix_valid;
        s1_inr_d       = in_range;
        s1_age_d       = (mode_eff == 2'd1) || (mode_eff == 2'd2);
        s1_grid_d      = (mode_eff == 2'd2) && on_grid_line;
        s1_cur_d       = cursor_en && blink_eff && (col == cursor_col) && (row == cursor_row);
        s1_hs_d        = hsync_in;
        s1_vs_d        = vsync_in;
    end

    // Colour selection, using RAM data that is valid during stage 2
    always_comb begin
        rgb_d       = RGB_BLACK;
        rgb_valid_d = s2_valid_q;
        if (s2_valid_q && s2_inr_q) begin
            if (s2_cur_q) begin
                rgb_d = RGB_CURSOR;
            end else if (s2_grid_q) begin
                rgb_d = RGB_GRID;
            end else if (s2_age_q) begin
                unique case (cell_rd_data)
                    2'b00:   rgb_d = RGB_BLACK;
                    2'b10:   rgb_d = RGB_RED;
                    2'b01:   rgb_d = RGB_YELLOW;
                    default: rgb_d = RGB_GREEN;
                endcase
            end else begin
                rgb_d = cell_rd_data[0] ? RGB_WHITE : RGB_BLACK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= 2'd0;
            fc_q           <= '0;
            blink_q        <= 1'b1;
            frame_blink_q  <= 1'b1;
            cell_rd_en_q   <= 1'b0;
            cell_rd_addr_q <= '0;
            s1_valid_q     <= 1'b0;
            s1_inr_q       <= 1'b0;
            s1_age_q       <= 1'b0;
            s1_grid_q      <= 1'b0;
            s1_cur_q       <= 1'b0;
            s1_hs_q        <= 1'b0;
            s1_vs_q        <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_inr_q       <= 1'b0;
            s2_age_q       <= 1'b0;
            s2_grid_q      <= 1'b0;
            s2_cur_q       <= 1'b0;
            s2_hs_q        <= 1'b0;
            s2_vs_q        <= 1'b0;
            rgb_q          <= RGB_BLACK;
            rgb_valid_q    <= 1'b0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            fc_q           <= fc_d;
            blink_q        <= blink_d;
            frame_blink_q  <= frame_blink_d;
            cell_rd_en_q   <= cell_rd_en_d;
            cell_rd_addr_q <= cell_rd_addr_d;
            s1_valid_q     <= s1_valid_d;
            s1_inr_q       <= s1_inr_d;
            s1_age_q       <= s1_age_d;
            s1_grid_q      <= s1_grid_d;
            s1_cur_q       <= s1_cur_d;
            s1_hs_q        <= s1_hs_d;
            s1_vs_q        <= s1_vs_d;
            s2_valid_q     <= s1_valid_q;
            s2_inr_q       <= s1_inr_q;
            s2_age_q       <= s1_age_q;
            s2_grid_q      <= s1_grid_q;
            s2_cur_q       <= s1_cur_q;
            s2_hs_q        <= s1_hs_q;
            s2_vs_q        <= s1_vs_q;
            rgb_q          <= rgb_d;
            rgb_valid_q    <= rgb_valid_d;
            hsync_q        <= s2_hs_q;
            vsync_q        <= s2_vs_q;
        end
    end

    assign cell_rd_en   = cell_rd_en_q;
    assign cell_rd_addr = cell_rd_addr_q;
    assign rgb          = rgb_q;
    assign rgb_valid    = rgb_valid_q;
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;

endmodule

// File: tb/tb_display_grid.sv
// Testbench for display_grid: table of pixel vectors with hand-computed
// colours, an expected-output queue aligned to the 3-cycle latency, and
// hand-written reset and blink sequences. Runs with BLINK_FRAMES = 2.
module tb_display_grid;

    logic        clk;
    logic        rst_n;
    logic        pix_valid;
    logic [10:0] x, y;
    logic        hsync_in, vsync_in;
    logic [1:0]  mode;
    logic        cursor_en;
    logic [1:0]  cursor_col, cursor_row;
    logic        cell_rd_en;
    logic [3:0]  cell_rd_addr;
    logic [1:0]  cell_rd_data;
    logic [11:0] rgb;
    logic        rgb_valid, hsync_out, vsync_out;

    display_grid #(
        .CELL_LOG2   (7),
        .COLS_LOG2   (2),
        .ROWS_LOG2   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode        (mode),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .cell_rd_en  (cell_rd_en),
        .cell_rd_addr(cell_rd_addr),
        .cell_rd_data(cell_rd_data),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell RAM model, {was_alive,is_alive}, one-cycle read latency
    logic [1:0] mem [16];
    always @(posedge clk) begin
        if (cell_rd_en) cell_rd_data <= mem[cell_rd_addr];
    end

    typedef struct {
        logic        pv;
        logic [10:0] px, py;
        logic [1:0]  md;
        logic        ce;
        logic [1:0]  cc, cr;
        logic        hs, vs;
        logic        exp_en;
        logic [3:0]  exp_addr;
        logic        exp_valid;
        logic [11:0] exp_rgb;
    } vec_t;

    typedef struct {
        int          idx;
        logic        valid;
        logic [11:0] col;
        logic        hs, vs;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   total = 0;
    int   bad   = 0;
    int   split;

    function automatic vec_t mk(bit pv, int xx, int yy, int md, bit ce, int cc, int cr,
                                bit h, bit v, bit en, int ad, bit vl, logic [11:0] c);
        vec_t r;
        r.pv = pv; r.px = 11'(xx); r.py = 11'(yy); r.md = 2'(md);
        r.ce = ce; r.cc = 2'(cc); r.cr = 2'(cr); r.hs = h; r.vs = v;
        r.exp_en = en; r.exp_addr = 4'(ad); r.exp_valid = vl; r.exp_rgb = c;
        return r;
    endfunction

    function automatic void add(bit pv, int xx, int yy, int md, bit ce, int cc, int cr,
                                bit h, bit v, bit en, int ad, bit vl, logic [11:0] c);
        tbl.push_back(mk(pv, xx, yy, md, ce, cc, cr, h, v, en, ad, vl, c));
    endfunction

    task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    // Drive one pixel, check the read port one edge later, and compare the
    // output belonging to the pixel driven three edges earlier.
    task automatic apply(vec_t v, int idx);
        sb_t e;
        pix_valid = v.pv; x = v.px; y = v.py; mode = v.md;
        cursor_en = v.ce; cursor_col = v.cc; cursor_row = v.cr;
        hsync_in = v.hs; vsync_in = v.vs;
        sb.push_back('{idx: idx, valid: v.exp_valid, col: v.exp_rgb, hs: v.hs, vs: v.vs});
        @(posedge clk);
        #1;
        check("rd_en", idx, 32'(cell_rd_en), 32'(v.exp_en));
        if (v.exp_en) check("rd_addr", idx, 32'(cell_rd_addr), 32'(v.exp_addr));
        if (sb.size() == 3) begin
            e = sb.pop_front();
            check("rgb_valid", e.idx, 32'(rgb_valid), 32'(e.valid));
            check("rgb", e.idx, 32'(rgb), 32'(e.col));
            check("hsync", e.idx, 32'(hsync_out), 32'(e.hs));
            check("vsync", e.idx, 32'(vsync_out), 32'(e.vs));
        end
    endtask

    task automatic check_idle_outputs(string name);
        check({name, "_rgb_valid"}, -1, 32'(rgb_valid), 32'd0);
        check({name, "_rgb"}, -1, 32'(rgb), 32'd0);
        check({name, "_rd_en"}, -1, 32'(cell_rd_en), 32'd0);
        check({name, "_hsync"}, -1, 32'(hsync_out), 32'd0);
        check({name, "_vsync"}, -1, 32'(vsync_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'b00;
        mem[1] = 2'b10; mem[2] = 2'b11; mem[5] = 2'b01;
        mem[6] = 2'b11; mem[9] = 2'b10; mem[15] = 2'b01;
        cell_rd_data = 2'b00;

        // Segment A: palettes, range limits, mode latching (cursor off)
        //  pv   x    y  md ce cc cr hs vs en ad vl rgb
        add(1,   0,   0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 12'h000);
        add(1, 128, 256, 1, 0, 0, 0, 0, 0, 1, 9, 1, 12'hF00);
        add(1, 300, 150, 1, 0, 0, 0, 1, 0, 1, 6, 1, 12'h0F0);
        add(1, 130, 140, 1, 0, 0, 0, 0, 1, 1, 5, 1, 12'hFF0);
        add(1, 512,  10, 1, 0, 0, 0, 1, 0, 0, 0, 1, 12'h000);
        add(0,   5,   5, 1, 0, 0, 0, 1, 1, 0, 0, 0, 12'h000);
        add(1,  10, 600, 1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h000);
        add(1, 511, 511, 1, 0, 0, 0, 0, 1, 1, 15, 1, 12'hFF0);
        add(1, 200,  10, 1, 0, 0, 0, 1, 0, 1, 1, 1, 12'hF00);
        add(1,   0,   0, 2, 0, 0, 0, 1, 0, 1, 0, 1, 12'h444);
        add(1, 256,  50, 2, 0, 0, 0, 0, 0, 1, 2, 1, 12'h444);
        add(1, 257,  51, 2, 0, 0, 0, 1, 1, 1, 2, 1, 12'h0F0);
        add(1, 300, 128, 2, 0, 0, 0, 0, 0, 1, 6, 1, 12'h444);
        add(1, 130, 140, 2, 0, 0, 0, 0, 1, 1, 5, 1, 12'hFF0);
        add(1, 600,   0, 2, 0, 0, 0, 1, 0, 0, 0, 1, 12'h000);
        add(1,   0,   0, 3, 0, 0, 0, 1, 0, 1, 0, 1, 12'h000);
        add(1, 130, 140, 3, 0, 0, 0, 0, 0, 1, 5, 1, 12'hFFF);
        add(1, 128, 256, 3, 0, 0, 0, 0, 0, 1, 9, 1, 12'h000);
        add(1, 300, 150, 3, 0, 0, 0, 0, 0, 1, 6, 1, 12'hFFF);
        add(1, 128, 256, 1, 0, 0, 0, 0, 0, 1, 9, 1, 12'h000);
        add(1, 130, 140, 1, 0, 0, 0, 0, 0, 1, 5, 1, 12'hFFF);
        add(1,   0,   0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 12'h000);
        add(1, 128, 256, 1, 0, 0, 0, 0, 0, 1, 9, 1, 12'hF00);
        add(1, 130, 140, 0, 0, 0, 0, 0, 0, 1, 5, 1, 12'hFF0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, i % 2, 1, 0, 0, 0, 12'h000);
        split = tbl.size();

        // Segment B: after reset mid-frame (mode 0), then the blink sequence
        add(1, 130, 140, 1, 0, 0, 0, 0, 0, 1, 5, 1, 12'hFFF);
        add(1, 300, 150, 2, 0, 0, 0, 0, 0, 1, 6, 1, 12'hFFF);
        for (int f = 0; f < 4; f++) begin
            add(1,   0,   0, 1, 1, 1, 1, 0, 1, 1, 0, 1, 12'h000);
            add(1, 200, 200, 1, 1, 1, 1, 0, 0, 1, 5, 1, (f < 2) ? 12'h00F : 12'hFF0);
        end
        add(1,   0,   0, 2, 1, 1, 1, 0, 1, 1, 0, 1, 12'h444);
        add(1, 200, 200, 2, 1, 1, 1, 0, 0, 1, 5, 1, 12'h00F);
        add(1, 128, 128, 2, 1, 1, 1, 1, 0, 1, 5, 1, 12'h00F);
        add(1, 200, 200, 2, 0, 1, 1, 0, 0, 1, 5, 1, 12'hFF0);
        add(1, 200, 200, 2, 1, 2, 1, 0, 1, 1, 5, 1, 12'hFF0);
        add(1, 300, 150, 2, 1, 2, 1, 0, 0, 1, 6, 1, 12'h00F);
        add(1, 600,  10, 2, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 1, i % 2, 0, 0, 0, 12'h000);

        // Initial reset
        pix_valid = 1'b0; x = '0; y = '0; mode = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < split; i++) apply(tbl[i], i);

        // Reset with pixels in flight
        apply(mk(1, 130, 140, 1, 0, 0, 0, 1, 1, 1, 5, 1, 12'hFF0), 100);
        apply(mk(1, 300, 150, 1, 0, 0, 0, 1, 1, 1, 6, 1, 12'h0F0), 101);
        apply(mk(1, 128, 256, 1, 0, 0, 0, 1, 1, 1, 9, 1, 12'hF00), 102);
        pix_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("inflight_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("post_reset_valid", i, 32'(rgb_valid), 32'd0);
        end

        for (int i = split; i < tbl.size(); i++) apply(tbl[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
